ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Behavioural/synthesizable RAM endpoint for the memory-side bus driven by the memory controller.
- Accepts `ramREN`/`ramWEN`/`ramaddr`/`ramstore` requests and answers on `ramstate`/`ramload` using the `ramstate_t` handshake (FREE, BUSY, ACCESS, ERROR).
- Access latency is programmable, so controller and cache arbitration can be exercised under realistic wait states.
- Serves as the RAM for system simulation and controller testbenches.

Parameters:
- LAT, 2, number of BUSY cycles before ACCESS (0 allowed).
- DEPTH, 1024, number of 32-bit words; power of two.
- AW, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- CLK  input  1  system clock, all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- ramREN  input  1  read request, held by controller until ACCESS is seen.
- ramWEN  input  1  write request, held by controller until ACCESS is seen.
- ramaddr  input  32  byte address (word_t); word index = ramaddr[AW+1:2].
- ramstore  input  32  write data (word_t).
- ramload  output  32  read data (word_t), registered.
- ramstate  output  2  ramstate_t response, registered.

Behaviour:
- Reset: only one clock and one reset exist. The reset is synchronous and active-high. RST high at a rising edge forces state IDLE, ramstate=FREE, ramload=0, cnt=0 and clears the latched op/addr. Memory contents are not reset. Reset mid-request aborts it, and any pending write is not committed.
- Request valid (REQ): exactly one of REN/WEN is high, and ramaddr[31:AW+2]==0.
- Request bad (BAD): REN&WEN both high, or the address is out of range.
- State IDLE (ramstate=FREE), at each edge:
  - BAD -> ERR.
  - REQ and LAT>0 -> WAIT; latch op and ramaddr; cnt=LAT-1.
  - REQ and LAT==0 -> ACC with the access performed at this edge.
  - Otherwise stay in IDLE.
- State WAIT (ramstate=BUSY):
  - Request dropped (REN=WEN=0) -> IDLE; nothing committed.
  - BAD -> ERR.
  - Op or address differs from the latched value -> restart: re-latch, cnt=LAT-1, stay in WAIT.
  - cnt==0 -> ACC with the access performed at this edge.
  - Otherwise cnt decrements.
- Access at entry to ACC:
  - Read: ramload <= mem[idx].
  - Write: mem[idx] <= ramstore sampled at this edge; ramload unchanged.
- Latency: a request first presented before edge E0 shows BUSY for exactly LAT cycles after E0, then ACCESS for exactly one cycle. Total LAT+1 cycles from E0 to ACCESS.
- State ACC (ramstate=ACCESS, one cycle): next edge is evaluated exactly as in IDLE. A still-asserted request is treated as a new back-to-back request, with a fresh LAT count. The controller must drop or change its request on seeing ACCESS.
- State ERR (ramstate=ERROR): stays while BAD holds. Otherwise it is evaluated as IDLE at that edge; REQ starts a new request directly.
- ramload holds its last read value in all non-ACC cycles.
- ramstate is a pure function of the state register; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined: ramaddr[1:0]!=0 with REN or WEN high is also classified BAD and produces ERROR.
- Undefined: ramaddr[1:0] is ignored and the access uses the word containing the address.

Test Plan:
- LAT=2: write 0xDEADBEEF to 0x40 -> after E0, BUSY, BUSY, ACCESS; controller drops WEN. Then read 0x40 -> ACCESS cycle with ramload=0xDEADBEEF. Reading an unwritten address is don't-care.
- LAT=0: read request at 0x8 -> ACCESS on the first cycle after E0, no BUSY. Holding REN for 3 edges -> ramstate sequence ACCESS, ACCESS, ACCESS (each a new access).
- Address change in WAIT: LAT=3, read 0x10, change to 0x14 after the first BUSY -> three more BUSY then ACCESS with mem[0x14]. Drop REN mid-WAIT -> FREE next cycle and no write committed (verify with a WEN variant).
- Both REN and WEN high, or ramaddr=0x0001_0000 with DEPTH=1024 -> ERROR while held. Clear to a valid read of 0x0 -> BUSY (LAT=2) sequence follows.
- RST asserted during WAIT of a write of 0x12345678 to 0x20 -> FREE and ramload=0 the cycle after. A later read of 0x20 returns the prior contents, not 0x12345678.
- RAM_ALIGN_CHECK_EN: read 0x42 -> ERROR when defined. When undefined, same data as 0x40 after LAT+1 cycles.

Source files
------------

// File: rtl/ram_responder.sv
// Synchronous RAM endpoint answering the memory controller with FREE/BUSY/ACCESS/ERROR after LAT wait states.
// Optional RAM_ALIGN_CHECK_EN: misaligned byte addresses are rejected with ERROR instead of being rounded down.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  // state | meaning
  // IDLE  | no request in flight, ramstate=FREE
  // WAIT  | request latched, counting down wait states, ramstate=BUSY
  // ACC   | access performed at entry, ramstate=ACCESS for one cycle
  // ERR   | malformed request held, ramstate=ERROR

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            op_wr;
  logic [31:0]     op_addr;
  logic            latch, access;
  logic            any_req, in_range, bad, req, same;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH];

  assign idx = ramaddr[AW+1:2];

  always_comb begin
    any_req  = ramREN | ramWEN;
    in_range = (ramaddr[31:AW+2] == '0);
`ifdef RAM_ALIGN_CHECK_EN
    bad = any_req & ((ramREN & ramWEN) | ~in_range | (ramaddr[1:0] != 2'b00));
`else
    bad = any_req & ((ramREN & ramWEN) | ~in_range);
`endif
    req  = any_req & ~bad;
    same = (op_wr == ramWEN) && (op_addr == ramaddr);
  end

  // ACC and ERR share IDLE's evaluation; ERR simply re-enters itself while BAD holds
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    access    = 1'b0;
    case (state)
      WAIT: begin
        if (!any_req) begin
          state_nxt = IDLE;
        end else if (bad) begin
          state_nxt = ERR;
        end else if (!same) begin
          latch   = 1'b1;
          cnt_nxt = CNT_INIT;
        end else if (cnt == '0) begin
          state_nxt = ACC;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        if (bad) begin
          state_nxt = ERR;
        end else if (req) begin
          if (LAT > 0) begin
            state_nxt = WAIT;
            latch     = 1'b1;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = ACC;
            access    = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      op_addr <= '0;
      ramload <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        op_wr   <= ramWEN;
        op_addr <= ramaddr;
      end
      if (access && !ramWEN) ramload <= mem[idx];
    end
  end

  // memory array is intentionally not reset
  always_ff @(posedge CLK) begin
    if (access && ramWEN && !RST) mem[idx] <= ramstore;
  end

  always_comb begin
    case (state)
      WAIT:    ramstate = BUSY;
      ACC:     ramstate = ACCESS;
      ERR:     ramstate = ERROR;
      default: ramstate = FREE;
    endcase
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LAT=2,0,3), directed scenarios then random traffic vs. a request-age model.
module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load  [3];
  logic [1:0]  st    [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_responder #(.LAT(g == 0 ? 2 : (g == 1 ? 0 : 3)), .DEPTH(1024)) u_dut (
      .CLK(clk), .RST(rst[g]), .ramREN(ren[g]), .ramWEN(wen[g]),
      .ramaddr(addr[g]), .ramstore(store[g]), .ramload(load[g]), .ramstate(st[g])
    );
  end

  // reference model: a valid request becomes ACCESS once it has been held unchanged for LAT edges
  int          m_age   [3];
  logic [1:0]  m_st    [3];
  logic [31:0] m_load  [3];
  bit          m_known [3];
  bit          m_wr    [3];
  logic [31:0] m_addr  [3];
  logic [31:0] m_mem   [3][1024];
  bit          m_val   [3][1024];

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(int i);
    bit any, bad, cont;
    int w;
    if (rst[i]) begin
      m_st[i] = FREE; m_load[i] = 0; m_known[i] = 1; m_age[i] = 0;
      return;
    end
    any = ren[i] || wen[i];
    bad = any && ((ren[i] && wen[i]) || (addr[i][31:12] != 0));
`ifdef RAM_ALIGN_CHECK_EN
    bad = bad || (any && addr[i][1:0] != 0);
`endif
    w = int'(addr[i][11:2]);
    if (bad) m_st[i] = ERROR;
    else if (!any) m_st[i] = FREE;
    else begin
      cont = (m_st[i] == BUSY) && (m_wr[i] == wen[i]) && (m_addr[i] == addr[i]);
      m_age[i] = cont ? m_age[i] + 1 : 0;
      m_wr[i] = wen[i];
      m_addr[i] = addr[i];
      if (m_age[i] == lat_of(i)) begin
        m_st[i] = ACCESS;
        if (wen[i]) begin
          m_mem[i][w] = store[i]; m_val[i][w] = 1;
        end else begin
          m_load[i] = m_mem[i][w]; m_known[i] = m_val[i][w];
        end
      end else m_st[i] = BUSY;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("state%0d@%0d", i, cyc), 32'(st[i]), 32'(m_st[i]));
      if (m_known[i]) check($sformatf("load%0d@%0d", i, cyc), load[i], m_load[i]);
    end
    cyc++;
  endtask

  task automatic drive(int i, bit r, bit w, logic [31:0] a, logic [31:0] d);
    ren[i] = r; wen[i] = w; addr[i] = a; store[i] = d;
  endtask

  task automatic step_expect(int i, string tag, logic [1:0] exp);
    step();
    check(tag, 32'(st[i]), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; drive(i, 0, 0, 0, 0);
      m_st[i] = FREE; m_known[i] = 0; m_age[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_load[i] = 0;
      for (int k = 0; k < 1024; k++) begin m_val[i][k] = 0; m_mem[i][k] = 0; end
    end
    step(); step();
    check("rst_state", 32'(st[0]), 32'(FREE));
    check("rst_load", load[0], 32'h0);
    for (int i = 0; i < 3; i++) rst[i] = 0;

    // LAT=2 write then read
    drive(0, 0, 1, 32'h40, 32'hDEADBEEF);
    step_expect(0, "w40_b0", BUSY);
    step_expect(0, "w40_b1", BUSY);
    step_expect(0, "w40_acc", ACCESS);
    drive(0, 1, 0, 32'h40, 0);
    step_expect(0, "r40_b0", BUSY);
    step_expect(0, "r40_b1", BUSY);
    step_expect(0, "r40_acc", ACCESS);
    check("r40_data", load[0], 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0);
    step_expect(0, "r40_free", FREE);

    // LAT=0 back-to-back
    drive(1, 0, 1, 32'h8, 32'h0BADF00D);
    step_expect(1, "lat0_w", ACCESS);
    drive(1, 1, 0, 32'h8, 0);
    for (int k = 0; k < 3; k++) begin
      step_expect(1, $sformatf("lat0_r%0d", k), ACCESS);
      check($sformatf("lat0_d%0d", k), load[1], 32'h0BADF00D);
    end
    drive(1, 0, 0, 0, 0);

    // LAT=3 address change restarts the count; dropped write is not committed
    drive(2, 0, 1, 32'h10, 32'hAAAA0010);
    repeat (4) step();
    drive(2, 0, 1, 32'h14, 32'hBBBB0014);
    repeat (4) step();
    drive(2, 1, 0, 32'h10, 0);
    step_expect(2, "chg_b0", BUSY);
    drive(2, 1, 0, 32'h14, 0);
    step_expect(2, "chg_b1", BUSY);
    step_expect(2, "chg_b2", BUSY);
    step_expect(2, "chg_b3", BUSY);
    step_expect(2, "chg_acc", ACCESS);
    check("chg_data", load[2], 32'hBBBB0014);
    drive(2, 0, 1, 32'h10, 32'hCCCC0010);
    step(); step();
    drive(2, 0, 0, 0, 0);
    step_expect(2, "drop_free", FREE);
    drive(2, 1, 0, 32'h10, 0);
    repeat (4) step();
    check("drop_data", load[2], 32'hAAAA0010);
    drive(2, 0, 0, 0, 0);

    // malformed requests
    drive(0, 1, 1, 32'h0, 0);
    step_expect(0, "both_e0", ERROR);
    step_expect(0, "both_e1", ERROR);
    drive(0, 1, 0, 32'h0001_0000, 0);
    step_expect(0, "oor_e0", ERROR);
    drive(0, 1, 0, 32'h0, 0);
    step_expect(0, "rec_b0", BUSY);
    step_expect(0, "rec_b1", BUSY);
    step_expect(0, "rec_acc", ACCESS);

    // reset during a pending write
    drive(0, 0, 1, 32'h20, 32'hCAFEF00D);
    repeat (3) step();
    drive(0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 32'h20, 32'h12345678);
    step_expect(0, "rstw_b0", BUSY);
    rst[0] = 1;
    step_expect(0, "rstw_free", FREE);
    check("rstw_load", load[0], 32'h0);
    rst[0] = 0; drive(0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 32'h20, 0);
    repeat (3) step();
    check("rstw_keep", load[0], 32'hCAFEF00D);
    drive(0, 0, 0, 0, 0);
    step();

    // misaligned read
    drive(0, 1, 0, 32'h42, 0);
`ifdef RAM_ALIGN_CHECK_EN
    step_expect(0, "mis_err", ERROR);
`else
    step_expect(0, "mis_b0", BUSY);
    step_expect(0, "mis_b1", BUSY);
    step_expect(0, "mis_acc", ACCESS);
    check("mis_data", load[0], 32'hDEADBEEF);
`endif
    drive(0, 0, 0, 0, 0);
    step();

    // random controller-like traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rst[i] = ($urandom_range(0, 99) == 0);
        if (m_st[i] == ACCESS && $urandom_range(0, 9) < 7) drive(i, 0, 0, 0, 0);
        else if ($urandom_range(0, 99) >= 80) begin
          int kind;
          logic [31:0] a;
          kind = $urandom_range(0, 9);
          a = 32'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
          if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
          drive(i, (kind >= 2 && kind <= 5) || kind == 9, kind >= 6, a, $urandom);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
